// File: rtl/pipe_dff.sv
// pipe_dff: enable-gated delay line for a WIDTH x ARRAY_SIZE1 x ARRAY_SIZE2 array, PIPE_DEPTH stages deep.
// Define PIPE_DFF_SYNC_CLEAR_EN to add the synchronous clear input `clr`.
module pipe_dff #(
  parameter int WIDTH         = 16,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef PIPE_DFF_SYNC_CLEAR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
  output logic [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);

  logic w_clr;
`ifdef PIPE_DFF_SYNC_CLEAR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  // Depth 0 and retimed builds leave some control inputs unread by design.
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, en, w_clr};

  if (WIDTH < 1 || ARRAY_SIZE1 < 1 || ARRAY_SIZE2 < 1 || PIPE_DEPTH < 0) begin : g_param_chk
    $error("pipe_dff: illegal parameter values");
  end

  if (PIPE_DEPTH == 0) begin : g_pass
    assign out = in;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stg [PIPE_DEPTH][ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];
    logic [WIDTH-1:0] w_nxt [PIPE_DEPTH][ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];

    // Clear beats enable; without either, every stage holds as a whole.
    always_comb begin
      w_nxt = r_stg;
      if (w_clr) begin
        for (int k = 0; k < PIPE_DEPTH; k++)
          for (int i = 0; i < ARRAY_SIZE1; i++)
            for (int j = 0; j < ARRAY_SIZE2; j++)
              w_nxt[k][i][j] = '0;
      end else if (en) begin
        w_nxt[0] = in;
        for (int k = 1; k < PIPE_DEPTH; k++)
          w_nxt[k] = r_stg[k-1];
      end
    end

    if (RETIME_STATUS == 0) begin : g_arst
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < PIPE_DEPTH; k++)
            for (int i = 0; i < ARRAY_SIZE1; i++)
              for (int j = 0; j < ARRAY_SIZE2; j++)
                r_stg[k][i][j] <= '0;
        end else begin
          r_stg <= w_nxt;
        end
      end
    end else begin : g_noreset
      // Reset-free stages so synthesis is free to retime them.
      always_ff @(posedge clk) r_stg <= w_nxt;
    end

    assign out = r_stg[PIPE_DEPTH-1];
  end

endmodule

// File: tb/tb_pipe_dff.sv
// Self-checking bench for pipe_dff: several parameterizations against queue-based delay-line models.
module tb_pipe_dff;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Scalar, WIDTH=32, depth 1
  logic        s_en;
  logic [31:0] s_in  [0:0][0:0];
  logic [31:0] s_out [0:0][0:0];
  // 3x3 array, WIDTH=24, depth 3
  logic        a_en;
  logic [23:0] a_in  [2:0][2:0];
  logic [23:0] a_out [2:0][2:0];
  // Stall / clear target, depth 2
  logic        st_en;
  logic [15:0] st_in  [0:0][0:0];
  logic [15:0] st_out [0:0][0:0];
  // Mid-stream reset target, depth 3
  logic        r_en;
  logic [15:0] r_in  [0:0][0:0];
  logic [15:0] r_out [0:0][0:0];
  // Passthrough, depth 0
  logic        p_en;
  logic [15:0] p_in  [0:0][0:0];
  logic [15:0] p_out [0:0][0:0];
  // Retimed (no reset), depth 2
  logic        t_en;
  logic [15:0] t_in  [0:0][0:0];
  logic [15:0] t_out [0:0][0:0];
`ifdef PIPE_DFF_SYNC_CLEAR_EN
  logic        st_clr;
`endif

  pipe_dff #(.WIDTH(32), .PIPE_DEPTH(1)) u_s (
    .clk(clk), .reset(rst_n), .en(s_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in(s_in), .out(s_out));

  pipe_dff #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3)) u_a (
    .clk(clk), .reset(rst_n), .en(a_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in(a_in), .out(a_out));

  pipe_dff #(.WIDTH(16), .PIPE_DEPTH(2)) u_st (
    .clk(clk), .reset(rst_n), .en(st_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(st_clr),
`endif
    .in(st_in), .out(st_out));

  pipe_dff #(.WIDTH(16), .PIPE_DEPTH(3)) u_r (
    .clk(clk), .reset(rst_n), .en(r_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in(r_in), .out(r_out));

  pipe_dff #(.WIDTH(16), .PIPE_DEPTH(0)) u_p (
    .clk(clk), .reset(rst_n), .en(p_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in(p_in), .out(p_out));

  pipe_dff #(.WIDTH(16), .PIPE_DEPTH(2), .RETIME_STATUS(1)) u_t (
    .clk(clk), .reset(rst_n), .en(t_en),
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in(t_in), .out(t_out));

  task automatic test_reset();
    logic [8:0][23:0] got;
    rst_n = 1'b0;
    s_en = 1'b1; a_en = 1'b1; st_en = 1'b1; r_en = 1'b1; p_en = 1'b0; t_en = 1'b0;
    s_in[0][0] = $urandom; st_in[0][0] = 16'($urandom); r_in[0][0] = 16'($urandom);
    p_in[0][0] = 16'h0; t_in[0][0] = 16'h0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) a_in[i][j] = 24'($urandom);
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    st_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (s_out[0][0] !== 32'h0) begin err_cnt++; $display("FAIL reset_scalar got=%h exp=0", s_out[0][0]); end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) got[i*3+j] = a_out[i][j];
    vec_cnt++;
    if (got !== '0) begin err_cnt++; $display("FAIL reset_array got=%h exp=0", got); end
    vec_cnt++;
    if (st_out[0][0] !== 16'h0) begin err_cnt++; $display("FAIL reset_d2 got=%h exp=0", st_out[0][0]); end
    vec_cnt++;
    if (r_out[0][0] !== 16'h0) begin err_cnt++; $display("FAIL reset_d3 got=%h exp=0", r_out[0][0]); end
    rst_n = 1'b1;
    s_en = 1'b0; a_en = 1'b0; st_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_scalar();
    logic [31:0] q[$];
    logic [31:0] v;
    q = {32'h0};
    for (int c = 0; c < 24; c++) begin
      v = (c < 3) ? 32'(5 + c) : $urandom;
      s_en = 1'b1; s_in[0][0] = v;
      q.push_back(v); q.delete(0);
      @(negedge clk);
      vec_cnt++;
      if (s_out[0][0] !== q[0]) begin
        err_cnt++; $display("FAIL scalar c=%0d got=%h exp=%h", c, s_out[0][0], q[0]);
      end
    end
    s_en = 1'b0;
  endtask

  task automatic test_array();
    logic [8:0][23:0] q[$];
    logic [8:0][23:0] v, got;
    q = {'0, '0, '0};
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < 9; k++)
        v[k] = (c == 0) ? 24'(10 * (k / 3) + (k % 3)) : (c == 1) ? 24'hFFFFFF : 24'($urandom);
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) a_in[i][j] = v[i*3+j];
      a_en = 1'b1;
      q.push_back(v); q.delete(0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) got[i*3+j] = a_out[i][j];
      vec_cnt++;
      if (got !== q[0]) begin
        err_cnt++; $display("FAIL array c=%0d got=%h exp=%h", c, got, q[0]);
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] q[$];
    logic [15:0] v;
    logic        e;
    int          nxt = 4;
    q = {16'h0, 16'h0};
    for (int c = 0; c < 40; c++) begin
      if (c < 3)       begin e = 1'b1; v = 16'(c + 1); end
      else if (c < 7)  begin e = 1'b0; v = 16'($urandom); end
      else if (c < 12) begin e = 1'b1; v = 16'(nxt); nxt++; end
      else             begin e = 1'($urandom_range(0, 1)); v = 16'($urandom); end
      st_en = e; st_in[0][0] = v;
      if (e) begin q.push_back(v); q.delete(0); end
      @(negedge clk);
      vec_cnt++;
      if (st_out[0][0] !== q[0]) begin
        err_cnt++; $display("FAIL stall c=%0d en=%b got=%h exp=%h", c, e, st_out[0][0], q[0]);
      end
    end
    st_en = 1'b0;
  endtask

  task automatic test_midreset();
    logic [15:0] q[$];
    logic [15:0] v;
    q = {16'h0, 16'h0, 16'h0};
    for (int c = 0; c < 3; c++) begin
      v = 16'(11 * (c + 1));
      r_en = 1'b1; r_in[0][0] = v;
      q.push_back(v); q.delete(0);
      @(negedge clk);
      vec_cnt++;
      if (r_out[0][0] !== q[0]) begin
        err_cnt++; $display("FAIL load c=%0d got=%h exp=%h", c, r_out[0][0], q[0]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (r_out[0][0] !== 16'h0) begin err_cnt++; $display("FAIL async_clear got=%h exp=0", r_out[0][0]); end
    @(negedge clk);
    vec_cnt++;
    if (r_out[0][0] !== 16'h0) begin err_cnt++; $display("FAIL reset_over_en got=%h exp=0", r_out[0][0]); end
    rst_n = 1'b1;
    q = {16'h0, 16'h0, 16'h0};
    for (int c = 0; c < 16; c++) begin
      v = (c == 0) ? 16'd44 : 16'($urandom);
      r_en = 1'b1; r_in[0][0] = v;
      q.push_back(v); q.delete(0);
      @(negedge clk);
      vec_cnt++;
      if (r_out[0][0] !== q[0]) begin
        err_cnt++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, r_out[0][0], q[0]);
      end
    end
    r_en = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [15:0] v;
    for (int c = 0; c < 12; c++) begin
      v = (c == 0) ? 16'hA : (c == 1) ? 16'hB : 16'($urandom);
      p_en = 1'($urandom_range(0, 1));
      p_in[0][0] = v;
      #1;
      vec_cnt++;
      if (p_out[0][0] !== v) begin
        err_cnt++; $display("FAIL passthrough c=%0d got=%h exp=%h", c, p_out[0][0], v);
      end
    end
  endtask

  task automatic test_retime();
    logic [15:0] q[$];
    logic [15:0] v;
    logic        e;
    int          fills = 0;
    q = {16'h0, 16'h0};
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      e = (c < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      v = 16'($urandom);
      t_en = e; t_in[0][0] = v;
      if (e) begin q.push_back(v); q.delete(0); fills++; end
      @(negedge clk);
      if (fills >= 2) begin
        vec_cnt++;
        if (t_out[0][0] !== q[0]) begin
          err_cnt++; $display("FAIL retime c=%0d got=%h exp=%h", c, t_out[0][0], q[0]);
        end
      end
    end
    rst_n = 1'b1;
    t_en = 1'b0;
  endtask

`ifdef PIPE_DFF_SYNC_CLEAR_EN
  task automatic test_clr();
    logic [15:0] q[$];
    logic [15:0] v;
    logic        e, k;
    q = {16'h0, 16'h0};
    for (int c = 0; c < 24; c++) begin
      if (c < 2)        begin e = 1'b1; k = 1'b0; v = 16'(7 + c); end
      else if (c == 2)  begin e = 1'b0; k = 1'b1; v = 16'($urandom); end
      else if (c == 12) begin e = 1'b1; k = 1'b1; v = 16'($urandom); end
      else              begin e = 1'($urandom_range(0, 1)); k = 1'b0; v = 16'($urandom); end
      st_en = e; st_clr = k; st_in[0][0] = v;
      if (k) q = {16'h0, 16'h0};
      else if (e) begin q.push_back(v); q.delete(0); end
      @(negedge clk);
      vec_cnt++;
      if (st_out[0][0] !== q[0]) begin
        err_cnt++; $display("FAIL clr c=%0d clr=%b got=%h exp=%h", c, k, st_out[0][0], q[0]);
      end
    end
    st_en = 1'b0; st_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scalar();
    test_array();
    test_stall();
    test_midreset();
    test_passthrough();
    test_retime();
`ifdef PIPE_DFF_SYNC_CLEAR_EN
    test_clr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
